// File: rtl/board_pkg.sv
// Shared connect-four board types.
//   light_t      : per-cell colour code (off / red / green)
//   col_state_t  : column controller states (IDLE, FALL)
//   valid_player : true only for the two playable colours
package board_pkg;

  typedef enum logic [1:0] {
    LIGHT_OFF   = 2'b00,
    LIGHT_RED   = 2'b01,
    LIGHT_GREEN = 2'b10
  } light_t;

  typedef enum logic {
    IDLE = 1'b0,
    FALL = 1'b1
  } col_state_t;

  function automatic logic valid_player(input light_t p);
    return (p == LIGHT_RED) || (p == LIGHT_GREEN);
  endfunction

endpackage

// File: rtl/fall_tick_counter.sv
// Free-running dwell counter for animations.
// Counts 0..FALL_TICKS-1 while en is high and wraps to 0 after the last tick;
// holds its value while en is low.
//   clock     : rising-edge clock
//   reset     : synchronous active-high, returns count to 0
//   en        : count enable
//   tick_last : high while enabled and count == FALL_TICKS-1
module fall_tick_counter #(
  parameter int FALL_TICKS = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  output logic tick_last
);

  localparam int CW = (FALL_TICKS > 1) ? $clog2(FALL_TICKS) : 1;

  logic [CW-1:0] count;

  assign tick_last = en && (count == CW'(FALL_TICKS - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      if (tick_last) count <= '0;
      else           count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/column_stack.sv
// One connect-four board column of ROWS cells (row 0 at the bottom).
// A drop request animates the piece from the top row down, FALL_TICKS cycles
// per row, then commits it into the lowest empty cell.
//   clock  : rising-edge clock
//   reset  : synchronous active-high; empties the column, returns to IDLE
//   drop   : single-cycle drop request, player sampled with it
//   player : 2'b01 red, 2'b10 green; other codes are rejected
//   clear  : synchronous new-game clear, same effect as reset, top priority
//   undo   : (only with COLUMN_STACK_UNDO_EN) remove the top piece in IDLE
//   lights : row r colour at [2r+1:2r]; falling piece overlaid at its row
//   height : number of committed pieces
//   full   : height == ROWS
//   busy   : a piece is falling
//   done   : one-cycle pulse after a commit (or a successful undo)
//   err    : one-cycle pulse after a rejected request
// Optional feature macro: COLUMN_STACK_UNDO_EN.
module column_stack
  import board_pkg::*;
#(
  parameter int ROWS       = 6,
  parameter int FALL_TICKS = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       drop,
  input  logic [1:0]                 player,
  input  logic                       clear,
`ifdef COLUMN_STACK_UNDO_EN
  input  logic                       undo,
`endif
  output logic [2*ROWS-1:0]          lights,
  output logic [$clog2(ROWS+1)-1:0]  height,
  output logic                       full,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int HW = $clog2(ROWS + 1);

  col_state_t          state;
  light_t              colour;
  logic [HW-1:0]       cursor;
  logic [2*ROWS-1:0]   cells;
  logic [2*ROWS-1:0]   overlay;
  logic                tick_last;
  logic                accept;

  fall_tick_counter #(
    .FALL_TICKS (FALL_TICKS)
  ) u_tick (
    .clock     (clock),
    .reset     (reset || clear),
    .en        (state == FALL),
    .tick_last (tick_last)
  );

  assign full   = (height == HW'(ROWS));
  assign busy   = (state == FALL);
  assign accept = drop && valid_player(light_t'(player)) && !full;

  // Cursor always sits on an empty cell, so OR-ing it in never corrupts a
  // committed piece.
  always_comb begin
    overlay = '0;
    if (state == FALL) overlay[2*int'(cursor) +: 2] = colour;
  end

  assign lights = cells | overlay;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      state  <= IDLE;
      colour <= LIGHT_OFF;
      cursor <= '0;
      cells  <= '0;
      height <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            colour <= light_t'(player);
            cursor <= HW'(ROWS - 1);
            state  <= FALL;
          end else if (drop) begin
            err <= 1'b1;
          end
`ifdef COLUMN_STACK_UNDO_EN
          // A simultaneous drop wins; the undo is then reported as rejected.
          if (undo) begin
            if (drop || (height == '0)) begin
              err <= 1'b1;
            end else begin
              cells[2*(int'(height)-1) +: 2] <= LIGHT_OFF;
              height <= height - 1'b1;
              done   <= 1'b1;
            end
          end
`endif
        end
        FALL: begin
`ifdef COLUMN_STACK_UNDO_EN
          if (drop || undo) err <= 1'b1;
`else
          if (drop) err <= 1'b1;
`endif
          if (tick_last) begin
            if (cursor > height) begin
              cursor <= cursor - 1'b1;
            end else begin
              cells[2*int'(height) +: 2] <= colour;
              height <= height + 1'b1;
              done   <= 1'b1;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_column_stack.sv
// Directed bench for column_stack with ROWS=6, FALL_TICKS=2.
module tb_column_stack;

  localparam int ROWS = 6;
  localparam int FT   = 2;

  logic        clock = 1'b0;
  logic        reset, drop, clear;
  logic [1:0]  player;
`ifdef COLUMN_STACK_UNDO_EN
  logic        undo;
`endif
  logic [11:0] lights;
  logic [2:0]  height;
  logic        full, busy, done, err;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  column_stack #(.ROWS(ROWS), .FALL_TICKS(FT)) dut (
    .clock  (clock),
    .reset  (reset),
    .drop   (drop),
    .player (player),
    .clear  (clear),
`ifdef COLUMN_STACK_UNDO_EN
    .undo   (undo),
`endif
    .lights (lights),
    .height (height),
    .full   (full),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; drop = 1'b0; clear = 1'b0; player = 2'b00;
`ifdef COLUMN_STACK_UNDO_EN
    undo = 1'b0;
`endif
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic pulse_drop(input logic [1:0] p);
    player = p;
    drop   = 1'b1;
    step();
    drop   = 1'b0;
  endtask

  task automatic wait_commit();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL commit_timeout: done=%b after %0d cycles, required 1", done, n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clock);
    checks++;
    if ({lights, height, full, busy, done, err} !== 19'd0) begin
      errors++;
      $display("FAIL reset_state: lights=%h height=%0d full=%b busy=%b done=%b err=%b, required all 0",
               lights, height, full, busy, done, err);
    end
  endtask

  task automatic test_first_drop();
    logic [11:0] exp_l;
    do_reset();
    pulse_drop(2'b10);
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      exp_l = 12'h002 << (2 * (5 - i / 2));
      checks++;
      if (busy !== 1'b1 || lights !== exp_l || done !== 1'b0) begin
        errors++;
        $display("FAIL fall_cursor[%0d]: busy=%b lights=%h done=%b, required busy=1 lights=%h done=0",
                 i, busy, lights, done, exp_l);
      end
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || lights !== 12'h002 || height !== 3'd1 || full !== 1'b0) begin
      errors++;
      $display("FAIL first_commit: done=%b busy=%b lights=%h height=%0d full=%b, required 1 0 002 1 0",
               done, busy, lights, height, full);
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse_width: done=%b, required 0", done);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      pulse_drop((k % 2 == 0) ? 2'b01 : 2'b10);
      wait_commit();
    end
    checks++;
    if (lights !== 12'b100110011001 || height !== 3'd6 || full !== 1'b1) begin
      errors++;
      $display("FAIL full_column: lights=%b height=%0d full=%b, required 100110011001 6 1",
               lights, height, full);
    end
    pulse_drop(2'b10);
    @(negedge clock);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_when_full: err=%b busy=%b, required err=1 busy=0", err, busy);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++;
      if (err !== 1'b0 || busy !== 1'b0 || lights !== 12'b100110011001 || height !== 3'd6) begin
        errors++;
        $display("FAIL full_after[%0d]: err=%b busy=%b lights=%b height=%0d, required 0 0 100110011001 6",
                 i, err, busy, lights, height);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    pulse_drop(2'b01); wait_commit();
    pulse_drop(2'b10); wait_commit();
    pulse_drop(2'b01); wait_commit();
    pulse_drop(2'b01);
    step();
    step();
    pulse_drop(2'b10);
    @(negedge clock);
    checks++;
    if (err !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL drop_during_fall: err=%b busy=%b, required err=1 busy=1", err, busy);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      checks++;
      if (busy !== 1'b1 || err !== 1'b0 || lights !== 12'b000001011001) begin
        errors++;
        $display("FAIL fall_row3[%0d]: busy=%b err=%b lights=%b, required 1 0 000001011001",
                 i, busy, err, lights);
      end
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || height !== 3'd4 || lights !== 12'b000001011001) begin
      errors++;
      $display("FAIL commit_row3: done=%b busy=%b height=%0d lights=%b, required 1 0 4 000001011001",
               done, busy, height, lights);
    end
  endtask

  task automatic test_invalid_player();
    pulse_drop(2'b11);
    @(negedge clock);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || height !== 3'd4) begin
      errors++;
      $display("FAIL invalid_11: err=%b busy=%b height=%0d, required 1 0 4", err, busy, height);
    end
    @(negedge clock);
    checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL invalid_11_after: err=%b busy=%b, required 0 0", err, busy);
    end
    pulse_drop(2'b00);
    @(negedge clock);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || height !== 3'd4) begin
      errors++;
      $display("FAIL invalid_00: err=%b busy=%b height=%0d, required 1 0 4", err, busy, height);
    end
  endtask

  task automatic test_clear();
    do_reset();
    pulse_drop(2'b01); wait_commit();
    pulse_drop(2'b10); wait_commit();
    pulse_drop(2'b01);
    step(); step(); step(); step();
    checks++;
    if (busy !== 1'b1 || height !== 3'd2) begin
      errors++;
      $display("FAIL pre_clear: busy=%b height=%0d, required 1 2", busy, height);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    @(negedge clock);
    checks++;
    if (lights !== 12'd0 || height !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL after_clear: lights=%h height=%0d busy=%b done=%b err=%b, required all 0",
               lights, height, busy, done, err);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || lights !== 12'd0) begin
        errors++;
        $display("FAIL clear_quiet[%0d]: done=%b busy=%b lights=%h, required 0 0 000", i, done, busy, lights);
      end
    end
  endtask

`ifdef COLUMN_STACK_UNDO_EN
  task automatic test_undo();
    do_reset();
    pulse_drop(2'b01); wait_commit();
    pulse_drop(2'b10); wait_commit();
    undo = 1'b1; step(); undo = 1'b0;
    @(negedge clock);
    checks++;
    if (done !== 1'b1 || height !== 3'd1 || lights !== 12'h001) begin
      errors++;
      $display("FAIL undo_1: done=%b height=%0d lights=%h, required 1 1 001", done, height, lights);
    end
    undo = 1'b1; step(); undo = 1'b0;
    @(negedge clock);
    checks++;
    if (done !== 1'b1 || height !== 3'd0 || lights !== 12'h000) begin
      errors++;
      $display("FAIL undo_2: done=%b height=%0d lights=%h, required 1 0 000", done, height, lights);
    end
    undo = 1'b1; step(); undo = 1'b0;
    @(negedge clock);
    checks++;
    if (err !== 1'b1 || done !== 1'b0 || height !== 3'd0) begin
      errors++;
      $display("FAIL undo_empty: err=%b done=%b height=%0d, required 1 0 0", err, done, height);
    end
    undo = 1'b1; player = 2'b01; drop = 1'b1; step(); undo = 1'b0; drop = 1'b0;
    @(negedge clock);
    checks++;
    if (err !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL drop_and_undo: err=%b busy=%b, required 1 1", err, busy);
    end
    wait_commit();
    checks++;
    if (height !== 3'd1 || lights !== 12'h001) begin
      errors++;
      $display("FAIL drop_and_undo_commit: height=%0d lights=%h, required 1 001", height, lights);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first_drop();
    test_fill();
    test_back_to_back();
    test_invalid_player();
    test_clear();
`ifdef COLUMN_STACK_UNDO_EN
    test_undo();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/column_stack.md
Name: column_stack

Overview:
- Parametrised successor of the single-cell light for the connect-four board. One instance owns one whole board column of ROWS cells.
- Accepts a drop request carrying a player colour and animates the piece falling from the top row, one row per FALL_TICKS cycles.
- Commits the piece into the lowest empty cell and reports height, full, busy, done and error status to the game controller.
- Board top level instantiates one per column.

Parameters:
- ROWS, 6, number of cells in the column; row 0 is the bottom; legal range 2..16.
- FALL_TICKS, 4, cycles the falling piece is shown on each row; minimum 1.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high; empties column, returns to IDLE.
- drop  input  1  single-cycle drop request.
- player  input  2  piece colour, sampled with drop: 2'b10 green, 2'b01 red; 2'b00 and 2'b11 are invalid.
- clear  input  1  synchronous new-game clear; same effect as reset.
- lights  output  2*ROWS  per-row colour, row r at bits [2r+1:2r]; 00 off, 01 red, 10 green.
- height  output  $clog2(ROWS+1)  number of committed pieces.
- full  output  1  high when height == ROWS.
- busy  output  1  high while a piece is falling.
- done  output  1  one-cycle pulse when a piece commits.
- err  output  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset/clear values: all cells 00, lights 0, height 0, full 0, busy 0, done 0, err 0, state IDLE.
- clear has priority over every other input in the same cycle. It aborts any fall, with no done and no err.
- States:
  - IDLE: waits for drop.
  - FALL: animates the piece and commits it.
- IDLE, drop with valid player and full==0:
  - Latch player, cursor <= ROWS-1, tick <= 0, state <= FALL.
  - busy rises the next cycle.
- IDLE, drop rejected (invalid player or full==1): err pulses the next cycle; no state change.
- FALL, cursor display: lights shows committed cells with the latched colour OR'd in at row cursor. Cursor is always >= height, so it always sits on an empty cell.
- FALL, tick advance: tick increments each cycle. At tick == FALL_TICKS-1, tick <= 0 and:
  - if cursor > height: cursor decrements;
  - else: commit. cell[height] <= colour, height <= height+1, state <= IDLE.
- Commit outputs: in the cycle after the commit edge, done=1, busy=0, updated lights/height/full are visible together.
- Timing: the cursor is visible on each of rows ROWS-1 down to height for exactly FALL_TICKS cycles. busy is high for (ROWS-height)*FALL_TICKS cycles.
- drop while in FALL: err pulses; the in-flight piece is unaffected.
- Committed cells never change except via reset, clear, or undo (optional feature).
- height never exceeds ROWS; full is derived combinationally from height.

Optional Feature:
- Macro: COLUMN_STACK_UNDO_EN.
- With the macro, an extra input undo (1 bit) is present:
  - In IDLE with height > 0: top cell <= 00 and height decrements; done pulses next cycle.
  - undo with height == 0, or undo while in FALL: err pulses.
  - drop and undo asserted together in IDLE: drop is processed, and err pulses for the undo.
- Without the macro: no undo port and no undo logic; committed pieces are permanent until clear/reset.

Decomposition:
- Shared package board_pkg holds:
  - enum light_t {LIGHT_OFF=2'b00, LIGHT_RED=2'b01, LIGHT_GREEN=2'b10};
  - enum col_state_t {IDLE, FALL};
  - function valid_player(light_t) returning 1 for RED/GREEN only.
- One sub-module: fall_tick_counter.
  - Parameter FALL_TICKS; inputs clock, reset, en.
  - Outputs tick_last (high when count == FALL_TICKS-1); count wraps to 0 after tick_last.
  - Reused by the board win-flash logic.

Test Plan (ROWS=6, FALL_TICKS=2):
- Reset, drop green on an empty column -> busy for 12 cycles with the cursor on rows 5,4,3,2,1,0 for 2 cycles each. Then lights[1:0]=10, height=1, done for 1 cycle.
- Six accepted drops alternating red/green -> lights=12'b100110011001, height=6, full=1. A seventh drop -> err for 1 cycle; lights unchanged; busy never rises.
- Drop red with height=3; drop green 3 cycles later -> err pulse. Red commits to row 3 after 6 busy cycles; row 4 stays 00.
- Drop with player=2'b11 in IDLE -> err for 1 cycle, busy stays 0, height unchanged.
- Clear asserted on the 5th cycle of a fall with height=2 -> next cycle lights=0, height=0, busy=0. No done pulse follows.
- With COLUMN_STACK_UNDO_EN, height=2 (rows 0/1 red/green): undo -> row 1 00, height=1, done pulses. A second and third undo -> height=0, then err.
